// File: rtl/lanes_pkg.sv
// Shared types and constants for the lane demultiplexer and its selector peer.
package lanes_pkg;

   localparam int LANES  = 4;
   localparam int DATA_W = 2;

   typedef logic [1:0]        lane_idx_t;
   typedef logic [DATA_W-1:0] lane_data_t;

   // Lane addressing mode taken from the mode switch.
   typedef enum logic {
      MODE_ADDR = 1'b0,
      MODE_SEQ  = 1'b1
   } mode_e;

   // Switch field positions; only sw[6:0] carry meaning.
   localparam int SW_DATA_LSB = 0;
   localparam int SW_SEL_LSB  = 2;
   localparam int SW_WR_BIT   = 4;
   localparam int SW_MODE_BIT = 5;
   localparam int SW_CLR_BIT  = 6;
   localparam int SW_USED_W   = 7;

   // LED field positions.
   localparam int LED_LANES_LSB = 0;
   localparam int LED_MASK_LSB  = 8;
   localparam int LED_PTR_LSB   = 12;
   localparam int LED_FULL_BIT  = 14;
   localparam int LED_OVF_BIT   = 15;

endpackage

// File: rtl/sync_edge.sv
// Multi-bit input synchronizer with a rising-edge pulse on one chosen bit.
// SYNC_STAGES must be at least 2.
module sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter int W           = 7,
   parameter int EDGE_BIT    = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] async_i,
   output logic [W-1:0] sync_o,
   output logic         rise_o
);

   logic [SYNC_STAGES-1:0][W-1:0] stage_q, stage_d;
   logic                          prev_q, prev_d;

   assign stage_d = {stage_q[SYNC_STAGES-2:0], async_i};
   assign prev_d  = stage_q[SYNC_STAGES-1][EDGE_BIT];

   assign sync_o  = stage_q[SYNC_STAGES-1];
   // A level held high yields a single pulse: only the 0->1 transition counts.
   assign rise_o  = stage_q[SYNC_STAGES-1][EDGE_BIT] & ~prev_q;

   // Synchronizer chain plus one-cycle delay of the edge bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q <= '0;
         prev_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the pre-edge value of its neighbour.
         stage_q <= stage_d;
         prev_q  <= prev_d;
      end
   end

endmodule

// File: rtl/demux41_lanes.sv
// Registered 1-to-4 demultiplexer: writes switch data into one of four lanes,
// addressed by switches or by an auto-incrementing pointer, and shows state on LEDs.
module demux41_lanes
   import lanes_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  sw,
   output logic [15:0] ledr
);

   logic [SW_USED_W-1:0] sw_s;
   logic                 wr;
   logic                 unused_sw;

   // The raw-level copy of the strobe and sw[9:7] carry no function here.
   assign unused_sw = ^{sw[9:7], sw_s[SW_WR_BIT]};

   sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .W           (SW_USED_W),
      .EDGE_BIT    (SW_WR_BIT)
   ) u_sync (
      .clk     (clk),
      .rst_n   (rst),
      .async_i (sw[SW_USED_W-1:0]),
      .sync_o  (sw_s),
      .rise_o  (wr)
   );

   lane_data_t [LANES-1:0] lanes_q, lanes_d;
   logic [LANES-1:0]       mask_q, mask_d;
   lane_idx_t              ptr_q, ptr_d;
   logic                   full_q, full_d;
   logic                   ovf_q, ovf_d;
   logic [15:0]            ledr_q, ledr_d;

   mode_e      mode;
   lane_idx_t  sel;
   lane_idx_t  target;
   lane_data_t data;
   logic       clr;

   assign mode   = mode_e'(sw_s[SW_MODE_BIT]);
   assign sel    = sw_s[SW_SEL_LSB +: 2];
   assign data   = sw_s[SW_DATA_LSB +: DATA_W];
   assign clr    = sw_s[SW_CLR_BIT];
   assign target = (mode == MODE_SEQ) ? ptr_q : sel;

   // Next lane/mask/pointer/flag state; clear dominates a same-cycle write.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
      lanes_d = lanes_q;
      mask_d  = mask_q;
      ptr_d   = ptr_q;
      ovf_d   = ovf_q;
      if (clr) begin
         lanes_d = '0;
         mask_d  = '0;
         ptr_d   = '0;
         ovf_d   = 1'b0;
      end else if (wr) begin
         lanes_d[target] = data;
         mask_d[target]  = 1'b1;
         if (mode == MODE_SEQ) begin
            ptr_d = ptr_q + lane_idx_t'(1);
            // A sequential write into an already full set overwrites an unread wrap.
            if (full_q) begin
               ovf_d = 1'b1;
            end
         end
      end
      full_d = &mask_d;
   end

   // Pack the current state into the LED image.
   always_comb begin
      ledr_d                                  = '0;
      ledr_d[LED_LANES_LSB +: LANES*DATA_W]   = lanes_q;
      ledr_d[LED_MASK_LSB +: LANES]           = mask_q;
      ledr_d[LED_PTR_LSB +: 2]                = ptr_q;
      ledr_d[LED_FULL_BIT]                    = full_q;
      ledr_d[LED_OVF_BIT]                     = ovf_q;
   end

   // Lane array, bookkeeping and LED output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the lane array is reset like any other flop because the LEDs must read zero out of reset.
         lanes_q <= '0;
         mask_q  <= '0;
         ptr_q   <= '0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         ledr_q  <= '0;
      end else begin
         lanes_q <= lanes_d;
         mask_q  <= mask_d;
         ptr_q   <= ptr_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
         ledr_q  <= ledr_d;
      end
   end

   assign ledr = ledr_q;

endmodule

// File: tb/tb_demux41_lanes.sv
// Self-checking bench for demux41_lanes: a cycle model compared every clock,
// plus hand-computed LED images at the key points of each scenario.
module tb_demux41_lanes;

   localparam int S = 2;

   logic        clk;
   logic        rst;
   logic [9:0]  sw;
   logic [15:0] ledr;

   int n_checks;
   int n_errors;

   demux41_lanes #(.SYNC_STAGES(S)) dut (
      .clk  (clk),
      .rst  (rst),
      .sw   (sw),
      .ledr (ledr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Synchronized switches equal the raw switches S edges earlier; a write happens
   // when the synchronized strobe is 1 and was 0 the cycle before. The LEDs show
   // the state as it was one edge earlier.
   logic [6:0] m_dly [S];
   logic       m_s4_prev;
   logic [1:0] m_lane [4];
   logic [3:0] m_mask;
   int         m_ptr;
   logic       m_ovf;
   logic [15:0] m_exp;

   function automatic logic [15:0] m_image();
      logic [15:0] img;
      img[7:0]   = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
      img[11:8]  = m_mask;
      img[13:12] = 2'(m_ptr);
      img[14]    = (m_mask == 4'hF);
      img[15]    = m_ovf;
      return img;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 4; i++) m_lane[i] = 2'b00;
      m_mask = 4'h0;
      m_ptr  = 0;
      m_ovf  = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < S; i++) m_dly[i] = '0;
      m_s4_prev = 1'b0;
      m_clear();
      m_exp = '0;
   end

   // Single compare process: advance the model at each edge, compare just after it.
   always @(posedge clk) begin
      logic [6:0] s_now;
      logic       wr;
      int         tgt;
      if (!rst) begin
         for (int i = 0; i < S; i++) m_dly[i] = '0;
         m_s4_prev = 1'b0;
         m_clear();
         m_exp = '0;
      end else begin
         s_now = m_dly[S-1];
         wr    = s_now[4] & ~m_s4_prev;
         m_exp = m_image();
         if (s_now[6]) begin
            m_clear();
         end else if (wr) begin
            tgt = s_now[5] ? m_ptr : int'(s_now[3:2]);
            if (s_now[5] && m_mask == 4'hF) m_ovf = 1'b1;
            m_lane[tgt]  = s_now[1:0];
            m_mask[tgt]  = 1'b1;
            if (s_now[5]) m_ptr = (m_ptr + 1) % 4;
         end
         m_s4_prev = s_now[4];
         for (int i = S - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
         m_dly[0] = sw[6:0];
      end
      #1;
      check("model_ledr", ledr, m_exp);
   end

   // ---------------- stimulus helpers ----------------
   // sw = {unused[9:7], clear, mode, strobe, sel[1:0], data[1:0]}
   task automatic do_write(input logic mode, input logic [1:0] sel, input logic [1:0] data);
      @(negedge clk);
      sw = {3'b000, 1'b0, mode, 1'b1, sel, data};
      repeat (3) @(negedge clk);
      sw[4] = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_clear();
      @(negedge clk);
      sw = 10'h040;
      repeat (4) @(negedge clk);
      sw = 10'h000;
      repeat (3) @(negedge clk);
   endtask

   task automatic settle_and_check(input string name, input logic [15:0] exp);
      @(posedge clk);
      #1;
      check(name, ledr, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenarios ----------------
   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b0;
      sw  = '0;

      // Reset with random switches: LEDs dark.
      repeat (4) begin
         @(negedge clk);
         sw = 10'($urandom);
         #1;
         check("reset_hold", ledr, 16'h0000);
      end
      @(negedge clk);
      sw  = '0;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("reset_idle", ledr, 16'h0000);

      // Addressed write: data 10 into lane 1, visible exactly after the 4th edge.
      @(negedge clk);
      sw = {3'b000, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10};
      repeat (3) @(posedge clk);
      #1;
      check("addr_not_yet", ledr, 16'h0000);
      @(posedge clk);
      #1;
      check("addr_write", ledr, 16'h0208);
      @(negedge clk);
      sw[4] = 1'b0;
      repeat (3) @(negedge clk);

      // Sequential fill 3,1,2,0 then a fifth write of 1.
      do_clear();
      settle_and_check("fill_cleared", 16'h0000);
      do_write(1'b1, 2'b00, 2'd3);
      do_write(1'b1, 2'b00, 2'd1);
      do_write(1'b1, 2'b00, 2'd2);
      do_write(1'b1, 2'b00, 2'd0);
      settle_and_check("seq_full", 16'h4F27);
      do_write(1'b1, 2'b00, 2'd1);
      settle_and_check("seq_overflow", 16'hDF25);

      // Strobe held for 20 cycles: one write into lane 1, pointer 1 -> 2.
      @(negedge clk);
      sw = {3'b000, 1'b0, 1'b1, 1'b1, 2'b00, 2'b11};
      repeat (20) @(negedge clk);
      sw[4] = 1'b0;
      repeat (4) @(negedge clk);
      settle_and_check("held_strobe", 16'hEF2D);

      // Addressed write after full: overwrite lane 3, overflow stays as it was.
      do_write(1'b0, 2'b11, 2'b01);
      settle_and_check("addr_after_full", 16'hEF6D);

      // Clear and strobe together: everything zero, write discarded.
      @(negedge clk);
      sw = {3'b000, 1'b1, 1'b1, 1'b1, 2'b00, 2'b10};
      repeat (5) @(negedge clk);
      settle_and_check("clear_priority", 16'h0000);
      @(negedge clk);
      sw[6] = 1'b0;
      repeat (5) @(negedge clk);
      settle_and_check("clear_discard", 16'h0000);
      @(negedge clk);
      sw[4] = 1'b0;
      repeat (3) @(negedge clk);
      do_write(1'b1, 2'b00, 2'b01);
      settle_and_check("after_clear_lane0", 16'h1101);

      // Reset one cycle after the write pulse: LEDs dark at once, data gone.
      @(negedge clk);
      sw = {3'b000, 1'b0, 1'b0, 1'b1, 2'b10, 2'b11};
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      sw  = '0;
      #1;
      check("reset_mid_op", ledr, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("reset_no_retain", ledr, 16'h0000);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
